// File: rtl/ls_unit.sv
// Load/store unit: takes one request at a time from the load/store buffer, drives a single
// memory-controller transaction, and reports load results on the CDB or store completion.
module ls_unit #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4,
    parameter int OPENUM_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                enable_signal_from_lsb,
    input  logic [OPENUM_W-1:0] openum_from_lsb,
    input  logic [ADDR_W-1:0]   mem_address_from_lsb,
    input  logic [DATA_W-1:0]   stored_data_from_lsb,
    input  logic [ROB_ID_W-1:0] rob_id_from_lsb,
    output logic                busy_signal_to_lsb,
    output logic                store_done_to_lsb,
    input  logic                rollback_signal,
    output logic                enable_signal_to_memctrl,
    output logic                rw_flag_to_memctrl,
    output logic [1:0]          size_to_memctrl,
    output logic [ADDR_W-1:0]   address_to_memctrl,
    output logic [DATA_W-1:0]   data_to_memctrl,
    input  logic                valid_signal_from_memctrl,
    input  logic [DATA_W-1:0]   data_from_memctrl,
    output logic                valid_signal_to_cdb,
    output logic [ROB_ID_W-1:0] rob_id_to_cdb,
    output logic [DATA_W-1:0]   result_to_cdb
);

    // Opcode encodings shared with the load/store buffer.
    localparam logic [OPENUM_W-1:0] OP_LB  = OPENUM_W'(1);
    localparam logic [OPENUM_W-1:0] OP_LH  = OPENUM_W'(2);
    localparam logic [OPENUM_W-1:0] OP_LW  = OPENUM_W'(3);
    localparam logic [OPENUM_W-1:0] OP_LBU = OPENUM_W'(4);
    localparam logic [OPENUM_W-1:0] OP_LHU = OPENUM_W'(5);
    localparam logic [OPENUM_W-1:0] OP_SB  = OPENUM_W'(6);
    localparam logic [OPENUM_W-1:0] OP_SH  = OPENUM_W'(7);
    localparam logic [OPENUM_W-1:0] OP_SW  = OPENUM_W'(8);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [OPENUM_W-1:0] r_op;
    logic [ROB_ID_W-1:0] r_rob_id;
    logic                r_mem_en;
    logic                r_rw;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_cdb_valid;
    logic [ROB_ID_W-1:0] r_cdb_id;
    logic [DATA_W-1:0]   r_result;
    logic                r_store_done;

    logic                w_accept;
    logic                w_abort;
    logic                w_complete;
    logic                w_in_rw;
    logic [1:0]          w_in_size;
    logic [DATA_W-1:0]   w_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else if (rdy) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_next_state = WAIT_MEM;
            WAIT_MEM: if (w_abort || w_complete) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // Rollback only aborts loads; a store in flight is already committed and must finish.
    always_comb begin
        w_accept           = (r_state == IDLE) && enable_signal_from_lsb && !rollback_signal;
        w_abort            = (r_state == WAIT_MEM) && rollback_signal && !r_rw;
        w_complete         = (r_state == WAIT_MEM) && valid_signal_from_memctrl && !w_abort;
        busy_signal_to_lsb = (r_state == WAIT_MEM);
    end

    always_comb begin
        w_in_rw   = 1'b0;
        w_in_size = 2'd2;
        case (openum_from_lsb)
            OP_LB, OP_LBU: w_in_size = 2'd0;
            OP_LH, OP_LHU: w_in_size = 2'd1;
            OP_LW:         w_in_size = 2'd2;
            OP_SB: begin w_in_rw = 1'b1; w_in_size = 2'd0; end
            OP_SH: begin w_in_rw = 1'b1; w_in_size = 2'd1; end
            OP_SW: begin w_in_rw = 1'b1; w_in_size = 2'd2; end
            default: ;
        endcase
    end

    always_comb begin
        w_ext = data_from_memctrl;
        case (r_op)
            OP_LB:  w_ext = {{(DATA_W-8){data_from_memctrl[7]}}, data_from_memctrl[7:0]};
            OP_LBU: w_ext = {{(DATA_W-8){1'b0}}, data_from_memctrl[7:0]};
            OP_LH:  w_ext = {{(DATA_W-16){data_from_memctrl[15]}}, data_from_memctrl[15:0]};
            OP_LHU: w_ext = {{(DATA_W-16){1'b0}}, data_from_memctrl[15:0]};
            default: ;
        endcase
    end

    // Pulse outputs default low each enabled cycle so they last exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op         <= '0;
            r_rob_id     <= '0;
            r_mem_en     <= 1'b0;
            r_rw         <= 1'b0;
            r_size       <= 2'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cdb_valid  <= 1'b0;
            r_cdb_id     <= '0;
            r_result     <= '0;
            r_store_done <= 1'b0;
        end else if (rdy) begin
            r_cdb_valid  <= 1'b0;
            r_store_done <= 1'b0;
            if (w_accept) begin
                r_op     <= openum_from_lsb;
                r_rob_id <= rob_id_from_lsb;
                r_addr   <= mem_address_from_lsb;
                r_wdata  <= stored_data_from_lsb;
                r_rw     <= w_in_rw;
                r_size   <= w_in_size;
                r_mem_en <= 1'b1;
            end else if (w_abort) begin
                r_mem_en <= 1'b0;
            end else if (w_complete) begin
                r_mem_en <= 1'b0;
                if (r_rw) begin
                    r_store_done <= 1'b1;
                end else begin
                    r_cdb_valid <= 1'b1;
                    r_cdb_id    <= r_rob_id;
                    r_result    <= w_ext;
                end
            end
        end
    end

    assign enable_signal_to_memctrl = r_mem_en;
    assign rw_flag_to_memctrl       = r_rw;
    assign size_to_memctrl          = r_size;
    assign address_to_memctrl       = r_addr;
    assign data_to_memctrl          = r_wdata;
    assign valid_signal_to_cdb      = r_cdb_valid;
    assign rob_id_to_cdb            = r_cdb_id;
    assign result_to_cdb            = r_result;
    assign store_done_to_lsb        = r_store_done;

endmodule

// File: tb/tb_ls_unit.sv
// Directed bench for ls_unit: a vector table of single transactions plus hand-written
// sequences for rollback, busy-time requests, rdy stalls and asynchronous reset.
module tb_ls_unit;

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        enIn;
    logic [5:0]  opIn;
    logic [31:0] addrIn;
    logic [31:0] wdataIn;
    logic [3:0]  idIn;
    logic        busy;
    logic        storeDone;
    logic        rollback;
    logic        memEn;
    logic        memRw;
    logic [1:0]  memSize;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memValid;
    logic [31:0] memRdata;
    logic        cdbValid;
    logic [3:0]  cdbId;
    logic [31:0] cdbResult;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    ls_unit dut (
        .clk                       (clk),
        .rst                       (rst),
        .rdy                       (rdy),
        .enable_signal_from_lsb    (enIn),
        .openum_from_lsb           (opIn),
        .mem_address_from_lsb      (addrIn),
        .stored_data_from_lsb      (wdataIn),
        .rob_id_from_lsb           (idIn),
        .busy_signal_to_lsb        (busy),
        .store_done_to_lsb         (storeDone),
        .rollback_signal           (rollback),
        .enable_signal_to_memctrl  (memEn),
        .rw_flag_to_memctrl        (memRw),
        .size_to_memctrl           (memSize),
        .address_to_memctrl        (memAddr),
        .data_to_memctrl           (memWdata),
        .valid_signal_from_memctrl (memValid),
        .data_from_memctrl         (memRdata),
        .valid_signal_to_cdb       (cdbValid),
        .rob_id_to_cdb             (cdbId),
        .result_to_cdb             (cdbResult)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  id;
        logic [31:0] mdata;
        int          delay;
        logic        expRw;
        logic [1:0]  expSize;
        logic [31:0] expResult;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] id);
        enIn    = 1'b1;
        opIn    = op;
        addrIn  = addr;
        wdataIn = wdata;
        idIn    = id;
        tick();
        enIn = 1'b0;
    endtask

    // One full transaction; during the wait a conflicting request is presented and must be ignored.
    task automatic applyStimulus(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        issue(v.op, v.addr, v.wdata, v.id);
        checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        checkOutput({tag, " memEn"}, 32'(memEn), 32'd1);
        checkOutput({tag, " rw"}, 32'(memRw), 32'(v.expRw));
        checkOutput({tag, " size"}, 32'(memSize), 32'(v.expSize));
        checkOutput({tag, " addr"}, memAddr, v.addr);
        checkOutput({tag, " wdata"}, memWdata, v.wdata);
        for (int i = 1; i < v.delay; i++) begin
            enIn    = 1'b1;
            opIn    = OP_SW;
            addrIn  = ~v.addr;
            wdataIn = ~v.wdata;
            tick();
            enIn = 1'b0;
            checkOutput({tag, " waitEn"}, 32'(memEn), 32'd1);
            checkOutput({tag, " waitAddr"}, memAddr, v.addr);
            checkOutput({tag, " waitRw"}, 32'(memRw), 32'(v.expRw));
        end
        memValid = 1'b1;
        memRdata = v.mdata;
        tick();
        memValid = 1'b0;
        memRdata = 32'h0;
        checkOutput({tag, " doneEn"}, 32'(memEn), 32'd0);
        checkOutput({tag, " doneBusy"}, 32'(busy), 32'd0);
        checkOutput({tag, " cdbValid"}, 32'(cdbValid), 32'(!v.expRw));
        checkOutput({tag, " storeDone"}, 32'(storeDone), 32'(v.expRw));
        if (!v.expRw) begin
            checkOutput({tag, " cdbId"}, 32'(cdbId), 32'(v.id));
            checkOutput({tag, " result"}, cdbResult, v.expResult);
        end
        tick();
        checkOutput({tag, " cdbPulseEnd"}, 32'(cdbValid), 32'd0);
        checkOutput({tag, " storePulseEnd"}, 32'(storeDone), 32'd0);
        checkOutput({tag, " idleBusy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{OP_LW,  32'h100, 32'h0,        4'd3,  32'hDEADBEEF, 3, 1'b0, 2'd2, 32'hDEADBEEF};
        vecs[1] = '{OP_LB,  32'h101, 32'h0,        4'd1,  32'h00000080, 1, 1'b0, 2'd0, 32'hFFFFFF80};
        vecs[2] = '{OP_LBU, 32'h101, 32'h0,        4'd2,  32'h00000080, 1, 1'b0, 2'd0, 32'h00000080};
        vecs[3] = '{OP_LH,  32'h102, 32'h0,        4'd4,  32'h00008001, 2, 1'b0, 2'd1, 32'hFFFF8001};
        vecs[4] = '{OP_LHU, 32'h102, 32'h0,        4'd5,  32'h00008001, 1, 1'b0, 2'd1, 32'h00008001};
        vecs[5] = '{OP_SB,  32'h300, 32'h000000AB, 4'd6,  32'h0,        1, 1'b1, 2'd0, 32'h0};
        vecs[6] = '{OP_SH,  32'h200, 32'h12345678, 4'd7,  32'h0,        2, 1'b1, 2'd1, 32'h0};
        vecs[7] = '{OP_SW,  32'h204, 32'hCAFEF00D, 4'd8,  32'h0,        1, 1'b1, 2'd2, 32'h0};
        vecs[8] = '{OP_LW,  32'hFFC, 32'h0,        4'd15, 32'h7FFFFFFF, 1, 1'b0, 2'd2, 32'h7FFFFFFF};

        rst      = 1'b0;
        rdy      = 1'b1;
        enIn     = 1'b0;
        opIn     = '0;
        addrIn   = '0;
        wdataIn  = '0;
        idIn     = '0;
        rollback = 1'b0;
        memValid = 1'b0;
        memRdata = '0;
        #1;
        checkOutput("rst memEn", 32'(memEn), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst cdbValid", 32'(cdbValid), 32'd0);
        checkOutput("rst addr", memAddr, 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // The first vector is presented right after reset release.
        for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);

        // Rollback one cycle into a load, with memctrl valid on the same edge.
        issue(OP_LW, 32'h400, 32'h0, 4'd9);
        tick();
        rollback = 1'b1;
        memValid = 1'b1;
        memRdata = 32'h55555555;
        tick();
        rollback = 1'b0;
        memValid = 1'b0;
        checkOutput("rb memEn", 32'(memEn), 32'd0);
        checkOutput("rb busy", 32'(busy), 32'd0);
        checkOutput("rb cdbValid", 32'(cdbValid), 32'd0);
        tick();
        checkOutput("rb cdbLater", 32'(cdbValid), 32'd0);

        // Rollback during a store is ignored.
        issue(OP_SW, 32'h500, 32'hA5A5A5A5, 4'd10);
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        checkOutput("rbStore busy", 32'(busy), 32'd1);
        checkOutput("rbStore memEn", 32'(memEn), 32'd1);
        memValid = 1'b1;
        tick();
        memValid = 1'b0;
        checkOutput("rbStore done", 32'(storeDone), 32'd1);
        checkOutput("rbStore cdb", 32'(cdbValid), 32'd0);
        tick();

        // Rollback together with a new request in IDLE drops it.
        rollback = 1'b1;
        issue(OP_LW, 32'h600, 32'h0, 4'd11);
        rollback = 1'b0;
        checkOutput("rbIdle busy", 32'(busy), 32'd0);
        checkOutput("rbIdle memEn", 32'(memEn), 32'd0);

        // rdy low for two cycles over the memctrl-valid edge.
        issue(OP_LH, 32'h700, 32'h0, 4'd12);
        memValid = 1'b1;
        memRdata = 32'h0000F00F;
        rdy      = 1'b0;
        tick();
        checkOutput("stall1 cdb", 32'(cdbValid), 32'd0);
        tick();
        checkOutput("stall2 cdb", 32'(cdbValid), 32'd0);
        checkOutput("stall2 busy", 32'(busy), 32'd1);
        rdy = 1'b1;
        tick();
        memValid = 1'b0;
        checkOutput("stall cdb", 32'(cdbValid), 32'd1);
        checkOutput("stall result", cdbResult, 32'hFFFFF00F);
        checkOutput("stall id", 32'(cdbId), 32'd12);
        rdy = 1'b0;
        tick();
        checkOutput("stall pulseHeld", 32'(cdbValid), 32'd1);
        rdy = 1'b1;
        tick();
        checkOutput("stall pulseEnd", 32'(cdbValid), 32'd0);

        // Asynchronous reset between edges in the middle of a load.
        issue(OP_LW, 32'h800, 32'h0, 4'd13);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst memEn", 32'(memEn), 32'd0);
        checkOutput("arst busy", 32'(busy), 32'd0);
        checkOutput("arst addr", memAddr, 32'd0);
        checkOutput("arst size", 32'(memSize), 32'd0);
        checkOutput("arst result", cdbResult, 32'd0);
        memValid = 1'b1;
        memRdata = 32'h11111111;
        tick();
        #2;
        rst = 1'b1;
        tick();
        checkOutput("arst noCdb", 32'(cdbValid), 32'd0);
        checkOutput("arst noStore", 32'(storeDone), 32'd0);
        checkOutput("arst idle", 32'(busy), 32'd0);
        memValid = 1'b0;
        issue(OP_LB, 32'h900, 32'h0, 4'd14);
        checkOutput("postRst accept", 32'(busy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
